// File: rtl/puf_response_reader.sv
// puf_response_reader: runs one split-counter race per response bit and
// assembles the winners into a RESP_BITS-wide response word.
// Optional feature macro: PUF_TIMEOUT_EN adds a RUN-state watchdog that
// forces a 0 bit and raises a sticky timeout_err when no counter finishes.
module puf_response_reader #(
   parameter int unsigned RESP_BITS   = 32,
   parameter int unsigned TIMEOUT_CYC = 4095
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 fin_a,
   input  logic                 fin_b,
   input  logic [21:0]          cnt_a,
   input  logic [21:0]          cnt_b,
   output logic                 cnt_clear,
   output logic                 cnt_enable,
   output logic [4:0]           sel,
   output logic [RESP_BITS-1:0] resp,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic                 busy,
   output logic                 timeout_err
);

   localparam int unsigned IDX_W = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CLEAR   = 3'd1,
      RUN     = 3'd2,
      COMPARE = 3'd3,
      DONE    = 3'd4
   } state_t;

   state_t               state_q;
   state_t               state_d;
   logic [IDX_W-1:0]     idx_q;
   logic [IDX_W-1:0]     idx_d;
   logic [RESP_BITS-1:0] resp_d;
   logic                 bit_q;
   logic                 bit_d;
   logic                 race_bit;
   logic                 wd_expire;

`ifdef PUF_TIMEOUT_EN
   localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);

   logic [WD_W-1:0] wd_q;
   logic [WD_W-1:0] wd_d;
   logic            terr_q;
   logic            terr_d;

   // Watchdog fires on the last allowed RUN cycle so RUN lasts exactly TIMEOUT_CYC cycles
   assign wd_expire   = (wd_q == WD_W'(TIMEOUT_CYC - 1));
   assign timeout_err = terr_q;

   // Watchdog counter and sticky error flag
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wd_q   <= '0;
         terr_q <= 1'b0;
      end else begin
         wd_q   <= wd_d;
         terr_q <= terr_d;
      end
   end
`else
   logic [31:0] unused_timeout_cfg;

   assign unused_timeout_cfg = 32'(TIMEOUT_CYC);
   assign wd_expire          = 1'b0;
   assign timeout_err        = 1'b0;
`endif

   // Race winner: a lone finisher decides; a simultaneous finish goes to the larger count
   always_comb begin
      race_bit = 1'b0;
      if (fin_a && !fin_b) begin
         race_bit = 1'b1;
      end else if (fin_a && fin_b) begin
         race_bit = (cnt_a > cnt_b);
      end
   end

   // Next-state and next-value logic for the sequencer
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      resp_d  = resp;
      bit_d   = bit_q;
`ifdef PUF_TIMEOUT_EN
      wd_d    = wd_q;
      terr_d  = terr_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = CLEAR;
               idx_d   = '0;
               resp_d  = '0;
`ifdef PUF_TIMEOUT_EN
               terr_d  = 1'b0;
`endif
            end
         end
         CLEAR: begin
            state_d = RUN;
`ifdef PUF_TIMEOUT_EN
            wd_d    = '0;
`endif
         end
         RUN: begin
`ifdef PUF_TIMEOUT_EN
            wd_d = WD_W'(wd_q + 1'b1);
`endif
            if (fin_a || fin_b) begin
               bit_d   = race_bit;
               state_d = COMPARE;
            end else if (wd_expire) begin
               bit_d   = 1'b0;
               state_d = COMPARE;
`ifdef PUF_TIMEOUT_EN
               terr_d  = 1'b1;
`endif
            end
         end
         COMPARE: begin
            resp_d[idx_q] = bit_q;
            if (idx_q == IDX_W'(RESP_BITS - 1)) begin
               state_d = DONE;
            end else begin
               idx_d   = IDX_W'(idx_q + 1'b1);
               state_d = CLEAR;
            end
         end
         DONE: begin
            if (resp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register; outputs are registered decodes of the next state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         resp       <= '0;
         bit_q      <= 1'b0;
         cnt_clear  <= 1'b0;
         cnt_enable <= 1'b0;
         resp_valid <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         resp       <= resp_d;
         bit_q      <= bit_d;
         cnt_clear  <= (state_d == CLEAR);
         cnt_enable <= (state_d == RUN);
         resp_valid <= (state_d == DONE);
         busy       <= (state_d != IDLE);
      end
   end

   assign sel = 5'(idx_q);

endmodule

// File: tb/tb_puf_response_reader.sv
// Self-checking bench for puf_response_reader (RESP_BITS=4, TIMEOUT_CYC=16).
module tb_puf_response_reader;

   localparam int unsigned RB = 4;
   localparam int unsigned TO = 16;

   // One response bit: fins are raised on RUN cycle r (r==0: never, watchdog expiry)
   typedef struct {
      int          r;
      bit          fa;
      bit          fb;
      logic [21:0] ca;
      logic [21:0] cb;
      bit          exp;
   } bitvec_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic          fin_a = 1'b0;
   logic          fin_b = 1'b0;
   logic [21:0]   cnt_a = '0;
   logic [21:0]   cnt_b = '0;
   logic          cnt_clear;
   logic          cnt_enable;
   logic [4:0]    sel;
   logic [RB-1:0] resp;
   logic          resp_valid;
   logic          resp_ready = 1'b0;
   logic          busy;
   logic          timeout_err;

   int            n_chk = 0;
   int            n_fail = 0;
   bitvec_t       tbl [3*RB];
   bitvec_t       cur [RB];
   bit            terr_exp = 1'b0;

   puf_response_reader #(.RESP_BITS(RB), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .reset(reset), .start(start), .fin_a(fin_a), .fin_b(fin_b),
      .cnt_a(cnt_a), .cnt_b(cnt_b), .cnt_clear(cnt_clear), .cnt_enable(cnt_enable),
      .sel(sel), .resp(resp), .resp_valid(resp_valid), .resp_ready(resp_ready),
      .busy(busy), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference decision from the race rules
   function automatic bit ref_bit(input bitvec_t v);
      if (v.r == 0)          return 1'b0;
      if (v.fa && !v.fb)     return 1'b1;
      if (v.fb && !v.fa)     return 1'b0;
      return (v.ca > v.cb);
   endfunction

   function automatic bitvec_t mk(input int r, input bit fa, input bit fb,
                                  input int unsigned ca, input int unsigned cb, input bit e);
      bitvec_t v;
      v.r = r; v.fa = fa; v.fb = fb; v.ca = 22'(ca); v.cb = 22'(cb); v.exp = e;
      return v;
   endfunction

   function automatic bitvec_t rnd_vec();
      bitvec_t v;
      int unsigned kind;
      kind = $urandom_range(0, 2);
      v.r  = int'($urandom_range(1, 6));
`ifdef PUF_TIMEOUT_EN
      if ($urandom_range(0, 7) == 0) v.r = 0;
`endif
      v.fa = (kind != 1);
      v.fb = (kind != 0);
      v.ca = 22'($urandom);
      v.cb = ($urandom_range(0, 3) == 0) ? v.ca : 22'($urandom);
      v.exp = ref_bit(v);
      return v;
   endfunction

   // Drive one full run from IDLE, checking cycle-by-cycle; ends at the first DONE cycle
   task automatic run_word(input bit poke_start, output logic [RB-1:0] exp);
      logic [RB-1:0] partial;
      bit            to_seen;
      int            rl;
      partial = '0;
      to_seen = 1'b0;
      for (int i = 0; i < RB; i++) exp[i] = cur[i].exp;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int b = 0; b < RB; b++) begin
         chk("clear_pulse", 64'(cnt_clear), 64'(1));
         chk("clear_no_enable", 64'(cnt_enable), 64'(0));
         chk("sel_clear", 64'(sel), 64'(b));
         chk("resp_partial", 64'(resp), 64'(partial));
         chk("busy_run", 64'(busy), 64'(1));
         chk("terr_clear", 64'(timeout_err), 64'(to_seen));
         rl = (cur[b].r == 0) ? int'(TO) : cur[b].r;
         for (int k = 1; k <= rl; k++) begin
            @(negedge clk);
            start = 1'b0;
            chk("run_enable", 64'(cnt_enable), 64'(1));
            chk("run_no_clear", 64'(cnt_clear), 64'(0));
            chk("sel_run", 64'(sel), 64'(b));
            chk("run_no_valid", 64'(resp_valid), 64'(0));
            if (poke_start && b == 1 && k == 1) start = 1'b1;
            if (k == rl && cur[b].r != 0) begin
               fin_a = cur[b].fa;
               fin_b = cur[b].fb;
               cnt_a = cur[b].ca;
               cnt_b = cur[b].cb;
            end
         end
         @(negedge clk);
         fin_a = 1'b0;
         fin_b = 1'b0;
         start = 1'b0;
         if (cur[b].r == 0) to_seen = 1'b1;
         chk("cmp_no_enable", 64'(cnt_enable), 64'(0));
         chk("cmp_no_clear", 64'(cnt_clear), 64'(0));
         chk("sel_cmp", 64'(sel), 64'(b));
         chk("cmp_timeout_err", 64'(timeout_err), 64'(to_seen));
         partial[b] = exp[b];
         @(negedge clk);
      end
      terr_exp = to_seen;
      chk("done_valid", 64'(resp_valid), 64'(1));
      chk("done_resp", 64'(resp), 64'(exp));
      chk("done_busy", 64'(busy), 64'(1));
   endtask

   // Hold resp_ready low for hold cycles (a stray start is poked meanwhile), then accept
   task automatic finish_word(input int hold, input logic [RB-1:0] exp);
      for (int i = 0; i < hold; i++) begin
         if (i == 0) start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         chk("hold_valid", 64'(resp_valid), 64'(1));
         chk("hold_resp", 64'(resp), 64'(exp));
         chk("hold_busy", 64'(busy), 64'(1));
      end
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      chk("accept_valid", 64'(resp_valid), 64'(0));
      chk("accept_busy", 64'(busy), 64'(0));
      @(negedge clk);
      chk("idle_resp_kept", 64'(resp), 64'(exp));
      chk("idle_no_enable", 64'(cnt_enable), 64'(0));
      chk("idle_terr_sticky", 64'(timeout_err), 64'(terr_exp));
   endtask

   initial begin
      logic [RB-1:0] exp;

      // Directed words: fin_a always first; simultaneous finishes; count extremes
      tbl[0]  = mk(1, 1, 0, 100, 50, 1'b1);
      tbl[1]  = mk(2, 1, 0, 5, 900, 1'b1);
      tbl[2]  = mk(3, 1, 0, 0, 0, 1'b1);
      tbl[3]  = mk(1, 1, 0, 7, 7, 1'b1);
      tbl[4]  = mk(2, 1, 1, 512, 513, 1'b0);
      tbl[5]  = mk(1, 1, 1, 514, 512, 1'b1);
      tbl[6]  = mk(3, 1, 1, 700, 700, 1'b0);
      tbl[7]  = mk(1, 0, 1, 9, 1, 1'b0);
      tbl[8]  = mk(1, 1, 1, 32'h3FFFFF, 0, 1'b1);
      tbl[9]  = mk(2, 1, 1, 0, 32'h3FFFFF, 1'b0);
      tbl[10] = mk(1, 0, 1, 32'h3FFFFF, 0, 1'b0);
      tbl[11] = mk(4, 1, 1, 32'h200000, 32'h1FFFFF, 1'b1);

      repeat (2) @(negedge clk);
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_valid", 64'(resp_valid), 64'(0));
      chk("rst_clear", 64'(cnt_clear), 64'(0));
      chk("rst_enable", 64'(cnt_enable), 64'(0));
      chk("rst_sel", 64'(sel), 64'(0));
      chk("rst_resp", 64'(resp), 64'(0));
      chk("rst_terr", 64'(timeout_err), 64'(0));
      reset = 1'b0;
      @(negedge clk);
      chk("idle_busy", 64'(busy), 64'(0));

      for (int w = 0; w < 3; w++) begin
         for (int i = 0; i < RB; i++) cur[i] = tbl[w*RB + i];
         run_word(w == 1, exp);
         finish_word((w == 0) ? 10 : 1, exp);
      end

      // Reset during RUN of bit 2, then a fresh start must begin at bit 0
      for (int i = 0; i < RB; i++) cur[i] = tbl[i];
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int b = 0; b < 2; b++) begin
         @(negedge clk);
         fin_a = 1'b1;
         @(negedge clk);
         fin_a = 1'b0;
         @(negedge clk);
      end
      @(negedge clk);
      chk("pre_rst_sel", 64'(sel), 64'(2));
      chk("pre_rst_enable", 64'(cnt_enable), 64'(1));
      #2 reset = 1'b1;
      #1;
      chk("async_busy", 64'(busy), 64'(0));
      chk("async_enable", 64'(cnt_enable), 64'(0));
      chk("async_clear", 64'(cnt_clear), 64'(0));
      chk("async_sel", 64'(sel), 64'(0));
      chk("async_resp", 64'(resp), 64'(0));
      chk("async_valid", 64'(resp_valid), 64'(0));
      @(negedge clk);
      reset = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("no_resume_busy", 64'(busy), 64'(0));
         chk("no_resume_valid", 64'(resp_valid), 64'(0));
      end
      run_word(1'b0, exp);
      finish_word(0, exp);

`ifdef PUF_TIMEOUT_EN
      // Bit 1 never finishes: watchdog records 0 and the run carries on
      cur[0] = mk(1, 1, 0, 3, 4, 1'b1);
      cur[1] = mk(0, 0, 0, 0, 0, 1'b0);
      cur[2] = mk(2, 1, 0, 1, 2, 1'b1);
      cur[3] = mk(1, 1, 0, 1, 2, 1'b1);
      run_word(1'b0, exp);
      chk("wd_resp", 64'(resp), 64'(4'b1101));
      finish_word(2, exp);
`endif

      for (int w = 0; w < 20; w++) begin
         for (int i = 0; i < RB; i++) cur[i] = rnd_vec();
         run_word(($urandom_range(0, 1) == 1), exp);
         finish_word(int'($urandom_range(0, 3)), exp);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
